// File: rtl/rv32i_types.sv
// Shared types and constants for the burst memory responder.
package rv32i_types;

    localparam int BEATS_PER_LINE = 4;
    localparam int BEAT_WIDTH     = 64;
    localparam int LINE_WIDTH     = BEATS_PER_LINE * BEAT_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

endpackage

// File: rtl/burst_line_store.sv
// Line storage: 2^ADDR_BITS lines of 256 bits, one synchronous read port and one write port.
module burst_line_store
    import rv32i_types::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  re,
    input  logic [ADDR_BITS-1:0]  raddr,
    output logic [LINE_WIDTH-1:0] rdata,
    input  logic                  we,
    input  logic [ADDR_BITS-1:0]  waddr,
    input  logic [LINE_WIDTH-1:0] wdata
);

    logic [LINE_WIDTH-1:0] mem [2**ADDR_BITS];

    // NOTE: the array has no reset branch; contents survive reset and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    // The read register does reset, so the beat mux reads zero after reset.
    always_ff @(posedge clk) begin
        if (!reset_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/burst_mem_responder.sv
// Line-burst memory responder: 4 x 64-bit beats per 256-bit line after a fixed latency.
// Optional MEM_RESP_JITTER_EN adds 0..3 LFSR-driven wait cycles per transaction.
module burst_mem_responder
    import rv32i_types::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mem_address,
    input  logic [BEAT_WIDTH-1:0] mem_wdata,
    output logic                  mem_resp,
    output logic [BEAT_WIDTH-1:0] mem_rdata,
    output logic                  proto_err
);

    state_t                    state;
    logic                      op_write;
    logic [ADDR_BITS-1:0]      index_q;
    logic [4:0]                wait_cnt;
    logic [1:0]                beat;
    logic [3*BEAT_WIDTH-1:0]   wbuf;
    logic [4:0]                delay;

    logic                      req_any;
    logic                      req_held;
    logic [ADDR_BITS-1:0]      req_index;
    logic                      store_re;
    logic                      store_we;
    logic [ADDR_BITS-1:0]      store_raddr;
    logic [LINE_WIDTH-1:0]     line_q;

    assign req_any   = mem_read | mem_write;
    assign req_held  = op_write ? mem_write : mem_read;
    assign req_index = mem_address[ADDR_BITS+4:5];

`ifdef MEM_RESP_JITTER_EN
    logic [3:0] lfsr;
    assign delay = 5'(LATENCY) + {3'b000, lfsr[1:0]};
`else
    assign delay = 5'(LATENCY);
`endif

    // With a one-cycle delay the fetch happens on the accepting edge, straight from the bus address.
    assign store_raddr = (state == IDLE) ? req_index : index_q;
    assign store_re    = reset_n &&
                         (((state == IDLE) && mem_read && (delay == 5'd1)) ||
                          ((state == WAIT) && !op_write && req_held && (wait_cnt == 5'd0)));
    assign store_we    = reset_n && (state == BURST) && op_write && req_held && (beat == 2'd3);

    burst_line_store #(
        .ADDR_BITS (ADDR_BITS)
    ) u_store (
        .clk     (clk),
        .reset_n (reset_n),
        .re      (store_re),
        .raddr   (store_raddr),
        .rdata   (line_q),
        .we      (store_we),
        .waddr   (index_q),
        .wdata   ({mem_wdata, wbuf})
    );

    // beat only moves during a burst, so the selected beat holds between transactions.
    assign mem_rdata = line_q[BEAT_WIDTH*beat +: BEAT_WIDTH];

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            mem_resp  <= 1'b0;
            proto_err <= 1'b0;
            op_write  <= 1'b0;
            index_q   <= '0;
            wait_cnt  <= '0;
            beat      <= '0;
            wbuf      <= '0;
`ifdef MEM_RESP_JITTER_EN
            lfsr      <= 4'hA;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        op_write <= mem_write && !mem_read;
                        index_q  <= req_index;
                        if (mem_read && mem_write)
                            proto_err <= 1'b1;
`ifdef MEM_RESP_JITTER_EN
                        lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
`endif
                        if (delay == 5'd1) begin
                            state    <= BURST;
                            mem_resp <= 1'b1;
                            beat     <= '0;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= delay - 5'd2;
                        end
                    end
                end
                WAIT: begin
                    if (!req_held) begin
                        state     <= IDLE;
                        proto_err <= 1'b1;
                    end else if (wait_cnt == 5'd0) begin
                        state    <= BURST;
                        mem_resp <= 1'b1;
                        beat     <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 5'd1;
                    end
                end
                BURST: begin
                    if (!req_held) begin
                        state     <= IDLE;
                        mem_resp  <= 1'b0;
                        proto_err <= 1'b1;
                    end else begin
                        if (op_write) begin
                            case (beat)
                                2'd0:    wbuf[0*BEAT_WIDTH +: BEAT_WIDTH] <= mem_wdata;
                                2'd1:    wbuf[1*BEAT_WIDTH +: BEAT_WIDTH] <= mem_wdata;
                                2'd2:    wbuf[2*BEAT_WIDTH +: BEAT_WIDTH] <= mem_wdata;
                                default: ;
                            endcase
                        end
                        if (beat == 2'd3) begin
                            state    <= DONE;
                            mem_resp <= 1'b0;
                        end else begin
                            beat <= beat + 2'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    mem_resp <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: LATENCY=4 instance for function, LATENCY=1 for back-to-back.
module tb_burst_mem_responder;
    import rv32i_types::*;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_address = '0;
    logic [63:0]  mem_wdata = '0;
    logic         mem_resp;
    logic [63:0]  mem_rdata;
    logic         proto_err;

    logic         b_read = 1'b0;
    logic [31:0]  b_address = '0;
    logic         b_resp;
    logic [63:0]  b_rdata;
    logic         b_err;

    int n_vec = 0;
    int n_err = 0;

    localparam int LAT = 4;
    localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] LINE_B = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003,
                                       64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    localparam logic [63:0]  JUNK   = 64'hDEAD_BEEF_F00D_CAFE;

    always #5 clk = ~clk;

    burst_mem_responder #(.ADDR_BITS(8), .LATENCY(LAT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .proto_err   (proto_err)
    );

    burst_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) dut_fast (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_read    (b_read),
        .mem_write   (1'b0),
        .mem_address (b_address),
        .mem_wdata   (64'h0),
        .mem_resp    (b_resp),
        .mem_rdata   (b_rdata),
        .proto_err   (b_err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction on the main DUT; requests drive at negedge, outputs sample at negedge.
    // Returns at the first low-mem_resp cycle after the beats (DONE, or IDLE after an abort/reset).
    task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wline, input int drop_beat, input int rst_beat,
                       output logic [255:0] rline, output int nbeats, output int first);
        bit done;
        done   = 1'b0;
        rline  = '0;
        nbeats = 0;
        first  = -1;
        @(negedge clk);
        mem_read    = rd;
        mem_write   = wr;
        mem_address = addr;
        mem_wdata   = JUNK;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            mem_address = addr ^ 32'hFFFF_FFE0;
            if (mem_resp) begin
                if (first < 0)
                    first = k;
                if (nbeats < 4) begin
                    rline[64*nbeats +: 64] = mem_rdata;
                    mem_wdata = wline[64*nbeats +: 64];
                end
                if (nbeats == drop_beat) begin
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
                if (nbeats == rst_beat)
                    reset_n = 1'b0;
                nbeats++;
            end else begin
                mem_wdata = JUNK;
                if (first >= 0) begin
                    done      = 1'b1;
                    mem_read  = 1'b0;
                    mem_write = 1'b0;
                end
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reset_n   = 1'b1;
        if (!done)
            check("txn_timeout", 256'd0, 256'd1);
    endtask

    task automatic check_latency(input string tag, input int first);
`ifdef MEM_RESP_JITTER_EN
        check(tag, 256'((first >= LAT) && (first <= LAT + 3)), 256'd1);
`else
        check(tag, 256'(first), 256'(LAT));
`endif
    endtask

    initial begin
        logic [255:0] rl;
        int nb;
        int fl;
        logic [31:0] got_pat;
        logic [31:0] exp_pat;
        int first_fast;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Idle after reset: outputs stay quiet.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_resp", 256'(mem_resp), 256'd0);
            check("idle_rdata", 256'(mem_rdata), 256'd0);
            check("idle_err", 256'(proto_err), 256'd0);
        end

        // Full write then read of line 0x40.
        txn(1'b0, 1'b1, 32'h0000_0040, LINE_A, -1, -1, rl, nb, fl);
        check("wr_beats", 256'(nb), 256'd4);
        check_latency("wr_first", fl);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, -1, -1, rl, nb, fl);
        check("rd_beats", 256'(nb), 256'd4);
        check_latency("rd_first", fl);
        check("rd_line", rl, LINE_A);
        check("rd_hold", 256'(mem_rdata), 256'(LINE_A[255:192]));
        check("rd_err", 256'(proto_err), 256'd0);

        // Address aliasing and ignored low bits.
        txn(1'b1, 1'b0, 32'h0000_2040, '0, -1, -1, rl, nb, fl);
        check("alias_line", rl, LINE_A);
        txn(1'b1, 1'b0, 32'h0000_005F, '0, -1, -1, rl, nb, fl);
        check("lowbits_line", rl, LINE_A);

        // Simultaneous read and write: read wins, error is sticky.
        txn(1'b1, 1'b1, 32'h0000_0040, LINE_B, -1, -1, rl, nb, fl);
        check("both_beats", 256'(nb), 256'd4);
        check("both_line", rl, LINE_A);
        check("both_err", 256'(proto_err), 256'd1);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, -1, -1, rl, nb, fl);
        check("both_nowrite", rl, LINE_A);
        check("err_sticky", 256'(proto_err), 256'd1);

        // Reset clears the flag; then a read dropped at beat 1 aborts.
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("err_cleared", 256'(proto_err), 256'd0);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, 1, -1, rl, nb, fl);
        check("abort_beats", 256'(nb), 256'd2);
        check("abort_resp", 256'(mem_resp), 256'd0);
        check("abort_err", 256'(proto_err), 256'd1);

        // A write dropped mid-burst must not commit.
        txn(1'b0, 1'b1, 32'h0000_0040, LINE_B, 2, -1, rl, nb, fl);
        check("wabort_beats", 256'(nb), 256'd3);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, -1, -1, rl, nb, fl);
        check("wabort_line", rl, LINE_A);

        // Reset during write beat 2: no commit, outputs cleared the next cycle.
        txn(1'b0, 1'b1, 32'h0000_0040, LINE_B, -1, 2, rl, nb, fl);
        check("rst_beats", 256'(nb), 256'd3);
        check("rst_resp", 256'(mem_resp), 256'd0);
        check("rst_rdata", 256'(mem_rdata), 256'd0);
        check("rst_err", 256'(proto_err), 256'd0);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, -1, -1, rl, nb, fl);
        check("rst_oldline", rl, LINE_A);

        // Top index line, and the earlier line is untouched.
        txn(1'b0, 1'b1, 32'h0000_1FE0, LINE_B, -1, -1, rl, nb, fl);
        txn(1'b1, 1'b0, 32'h0000_1FE0, '0, -1, -1, rl, nb, fl);
        check("top_line", rl, LINE_B);
        txn(1'b1, 1'b0, 32'h0000_0040, '0, -1, -1, rl, nb, fl);
        check("other_line", rl, LINE_A);

        // LATENCY=1 with the read held continuously: 4 beats, 2 idle cycles, repeat.
        @(negedge clk);
        b_read    = 1'b1;
        b_address = 32'h0000_0040;
        got_pat    = '0;
        exp_pat    = '0;
        first_fast = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            got_pat[k] = b_resp;
            exp_pat[k] = ((k - 1) % 6) < 4;
            if (b_resp && first_fast < 0)
                first_fast = k;
        end
        b_read = 1'b0;
`ifdef MEM_RESP_JITTER_EN
        check("fast_first", 256'((first_fast >= 1) && (first_fast <= 4)), 256'd1);
`else
        check("fast_first", 256'(first_fast), 256'd1);
        check("fast_pattern", 256'(got_pat), 256'(exp_pat));
`endif
        check("fast_err", 256'(b_err), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/burst_mem_responder.md
BURST_MEM_RESPONDER -- requirements
Module: burst_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8: line-index width, giving 2^ADDR_BITS lines of 256 bits.
REQ-002 SHALL have parameter LATENCY, default 4: cycles from request acceptance to the first response beat; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port mem_read, input, 1 bit: line read request, held by the requester until the last beat.
REQ-006 SHALL have port mem_write, input, 1 bit: line write request, held by the requester until the last beat.
REQ-007 SHALL have port mem_address, input, 32 bits: line address; bits [4:0] are ignored.
REQ-008 SHALL have port mem_wdata, input, 64 bits: write beat, sampled in every cycle in which mem_resp is high during a write.
REQ-009 SHALL have port mem_resp, output, 1 bit: beat valid, high for exactly 4 consecutive cycles per transaction.
REQ-010 SHALL have port mem_rdata, output, 64 bits: read beat, valid while mem_resp is high.
REQ-011 SHALL have port proto_err, output, 1 bit: sticky protocol-violation flag.

Function
REQ-012 SHALL implement the FSM states IDLE, WAIT, BURST and DONE.
REQ-013 In IDLE, if mem_read or mem_write is high, SHALL latch the operation and index = mem_address[ADDR_BITS+4:5], then go to WAIT; upper address bits alias (wrap).
REQ-014 If mem_read and mem_write are high together in IDLE, SHALL service a read and set proto_err.
REQ-015 In WAIT, SHALL count so that, for acceptance at cycle T, the first beat is at cycle T+LATENCY, then go to BURST.
REQ-016 In BURST, SHALL assert mem_resp in cycles T+LATENCY..T+LATENCY+3 with beat counter 0..3; beat k carries line bits [64k+63:64k].
REQ-017 For a read, the line SHALL be fetched from storage on the WAIT-to-BURST transition.
REQ-018 For a write, beats SHALL be assembled and the full line committed on the edge that ends beat 3; no partial commits.
REQ-019 Between beats, mem_rdata SHALL hold its last value.
REQ-020 DONE SHALL last one cycle with mem_resp low and requests ignored, then go to IDLE; the earliest next acceptance is T+LATENCY+5.
REQ-021 If the latched request deasserts during WAIT or BURST, SHALL abort to IDLE next cycle, set proto_err, and discard any pending write.
REQ-022 mem_address and mem_wdata changes outside response cycles SHALL be ignored after acceptance.
REQ-023 A read accepted after a write's DONE SHALL return the newly written line.

Reset
REQ-024 When reset_n is low at a clock edge, SHALL force state=IDLE, mem_resp=0, mem_rdata=0, proto_err=0, and counters=0.
REQ-025 Reset mid-transaction SHALL abort without committing write data.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With MEM_RESP_JITTER_EN defined, each transaction SHALL add 0..3 extra WAIT cycles, taken from lfsr[1:0].
REQ-028 The lfsr SHALL be a 4-bit maximal LFSR, reset to 4'hA and stepped once per acceptance.
REQ-029 With MEM_RESP_JITTER_EN defined, the 4 beats SHALL remain back-to-back.
REQ-030 Without MEM_RESP_JITTER_EN, latency SHALL be exactly LATENCY and no LFSR logic SHALL exist.

Structure
REQ-031 The state enum typedef and the constants BEATS_PER_LINE=4 and BEAT_WIDTH=64 SHALL reside in rv32i_types.
REQ-032 Line storage SHALL be the sub-module burst_line_store: 2^ADDR_BITS x 256, one synchronous read port and one write port.
REQ-033 The FSM, counters and beat mux/assembly SHALL reside in burst_mem_responder.

Verification
REQ-034 Reset release, idle: mem_resp=0, mem_rdata=0 and proto_err=0 for 20 cycles with no requests.
REQ-035 Write 0x00000040 with beats 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444..., then read 0x00000040: mem_resp in cycles T+4..T+7 with beats returned in order, and DONE gap honored.
REQ-036 Read 0x00002040 with ADDR_BITS=8 after REQ-035: the same line is returned (alias wrap), and read 0x0000005F returns the line at index 2.
REQ-037 mem_read and mem_write both high: read served and proto_err=1 until reset; mem_read dropped at beat 1: abort to IDLE and proto_err=1.
REQ-038 reset_n low at write beat 2: no commit, a later read returns the old line, and mem_resp=0 the cycle after the reset edge.
REQ-039 LATENCY=1, back-to-back reads held continuously: acceptances 6 cycles apart with no duplicate service; with MEM_RESP_JITTER_EN, first-beat delay stays within 1..4 cycles.
